// File: rtl/img_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate read cache between the CPU image
// ports and a word-wide backing memory; also produces the CPU read/write ready pulses.
module img_cache_ctrl #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 8,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16,
    parameter int CNT_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cpu_raddr,
    input  logic                  cpu_re,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rready,
    input  logic [ADDR_WIDTH-1:0] cpu_waddr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_we,
    output logic                  cpu_wready,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WORDS = NUM_LINES * LINE_WORDS;

    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [1:0]           state;
    logic                 flush_pend;
    logic                 done_is_wr;
    logic [OFF_W-1:0]     word_cnt;
    logic [NUM_LINES-1:0] valid_q;

    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_q [WORDS];

    logic [ADDR_WIDTH-1:0] fill_addr_p0;
    logic [ADDR_WIDTH-1:0] wr_addr_p0;
    logic [DATA_WIDTH-1:0] wr_data_p0;

    logic [TAG_W-1:0] rd_tag, f_tag, w_tag;
    logic [IDX_W-1:0] rd_idx, f_idx, w_idx;
    logic [OFF_W-1:0] rd_off, f_off, w_off;

    assign {rd_tag, rd_idx, rd_off} = cpu_raddr;
    assign {f_tag, f_idx, f_off}    = fill_addr_p0;
    assign {w_tag, w_idx, w_off}    = wr_addr_p0;

    logic                  rd_hit;
    logic                  wr_hit;
    logic                  fill_last;
    logic [DATA_WIDTH-1:0] fill_word;

    assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign wr_hit    = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign fill_last = mem_ack && (word_cnt == LAST_WORD);
    // On the last ack the requested word may be the one arriving on mem_rdata.
    assign fill_word = (f_off == word_cnt) ? mem_rdata : data_q[{f_idx, f_off}];

    // Control stage: FSM, valid bits, read data register and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
            done_is_wr <= 1'b0;
            word_cnt   <= '0;
            valid_q    <= '0;
            cpu_rdata  <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            if (flush && state != IDLE) flush_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (flush || flush_pend) begin
                        valid_q    <= '0;
                        flush_pend <= 1'b0;
                    end else if (cpu_we) begin
                        state <= WRITE;
                    end else if (cpu_re) begin
                        if (rd_hit) begin
                            cpu_rdata  <= data_q[{rd_idx, rd_off}];
                            hit_cnt    <= sat_inc(hit_cnt);
                            done_is_wr <= 1'b0;
                            state      <= DONE;
                        end else begin
                            miss_cnt <= sat_inc(miss_cnt);
                            word_cnt <= '0;
                            state    <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        word_cnt <= word_cnt + OFF_W'(1);
                        if (fill_last) begin
                            valid_q[f_idx] <= 1'b1;
                            cpu_rdata      <= fill_word;
                            done_is_wr     <= 1'b0;
                            state          <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        done_is_wr <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data stage: request capture, tag and line storage
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            fill_addr_p0 <= cpu_raddr;
            wr_addr_p0   <= cpu_waddr;
            wr_data_p0   <= cpu_wdata;
        end
        if (state == FILL && mem_ack) begin
            data_q[{f_idx, word_cnt}] <= mem_rdata;
            if (fill_last) tag_q[f_idx] <= f_tag;
        end
        if (state == WRITE && mem_ack && wr_hit) begin
            data_q[{w_idx, w_off}] <= wr_data_p0;
        end
    end

    assign mem_req    = (state == FILL) || (state == WRITE);
    assign mem_we     = (state == WRITE);
    assign cpu_rready = (state == DONE) && !done_is_wr;
    assign cpu_wready = (state == DONE) && done_is_wr;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == FILL) begin
            mem_addr = {f_tag, f_idx, word_cnt};
        end else if (state == WRITE) begin
            mem_addr  = wr_addr_p0;
            mem_wdata = wr_data_p0;
        end
    end

endmodule
